serial_add_arbiter: RTL and testbench



---
 rtl/serial_add_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_serial_add_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: round-robin sharing of one bit-serial adder between
// N_REQ requesters. A granted pair of parallel operands is streamed LSB-first
// into the adder, and the serial sum is gathered back into a parallel result
// that is held until the consumer takes it.
//
// Build option: define SERIAL_ADD_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins, no rotating pointer). Round-robin is the default.
module serial_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_vld,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_rdy,
  output logic                     res_vld,
  input  logic                     res_rdy,
  output logic [WIDTH-1:0]         res_sum,
  output logic [N_REQ-1:0]         res_gnt,
  output logic                     sa_rst,
  output logic                     sa_vld,
  output logic                     sa_a,
  output logic                     sa_b,
  output logic                     sa_last,
  input  logic                     sa_sum
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       sa_rst_sh_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sum_r;
  logic [N_REQ-1:0] res_gnt_r;
  logic             res_vld_r;
  logic             sa_vld_r;
  logic             sa_last_r;

  logic [PW-1:0]    gnt_idx_s;
  logic             gnt_any_s;
  logic [N_REQ-1:0] gnt_oh_s;
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic             accept_s;

`ifndef SERIAL_ADD_ARB_FIXED_PRIO_EN
  logic [PW-1:0]    ptr_r;
  logic [PW:0]      rr_idx_s;
`endif

  // Pick the requester to serve: scan offsets from the far end down so the
  // nearest set bit at or after the pointer is the one that sticks.
  always_comb begin
    gnt_idx_s = '0;
    gnt_any_s = 1'b0;
`ifndef SERIAL_ADD_ARB_FIXED_PRIO_EN
    rr_idx_s  = '0;
`endif
    for (int off = N_REQ - 1; off >= 0; off--) begin
`ifdef SERIAL_ADD_ARB_FIXED_PRIO_EN
      if (req_vld[off]) begin
        gnt_idx_s = PW'(off);
        gnt_any_s = 1'b1;
      end else begin
        gnt_any_s = gnt_any_s;
      end
`else
      rr_idx_s = {1'b0, ptr_r} + (PW+1)'(off);
      if (rr_idx_s >= (PW+1)'(N_REQ)) begin
        rr_idx_s = rr_idx_s - (PW+1)'(N_REQ);
      end else begin
        rr_idx_s = rr_idx_s;
      end
      if (req_vld[rr_idx_s]) begin
        gnt_idx_s = rr_idx_s[PW-1:0];
        gnt_any_s = 1'b1;
      end else begin
        gnt_any_s = gnt_any_s;
      end
`endif
    end
  end

  // Decode the grant to one-hot and select the granted requester's operands.
  always_comb begin
    gnt_oh_s = '0;
    gnt_oh_s[gnt_idx_s] = 1'b1;
    op_a_s = '0;
    op_b_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx_s == PW'(i)) begin
        op_a_s = req_a[i*WIDTH +: WIDTH];
        op_b_s = req_b[i*WIDTH +: WIDTH];
      end else begin
        op_a_s = op_a_s;
      end
    end
  end

  // Accept only when idle and the adder is out of reset; the accept pulse is
  // the handshake itself, so it has to be visible in the granting cycle.
  always_comb begin
    accept_s = (state_r == ST_IDLE) && !sa_rst_sh_r[1] && gnt_any_s;
    if (accept_s) begin
      req_rdy = gnt_oh_s;
    end else begin
      req_rdy = '0;
    end
  end

  // Hold the adder reset for two clocks after release so its carry is clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sa_rst_sh_r <= 2'b11;
    end else begin
      sa_rst_sh_r <= {sa_rst_sh_r[0], 1'b0};
    end
  end

`ifndef SERIAL_ADD_ARB_FIXED_PRIO_EN
  // Advance the round-robin pointer past the requester just served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= '0;
    end else if (accept_s) begin
      if (gnt_idx_s == PW'(N_REQ - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= gnt_idx_s + PW'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // Main sequencer: capture operands, stream bits, gather sum, hold result.
  // The operand shifters fill with zeros, so sa_a/sa_b are 0 outside RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      a_sh_r    <= '0;
      b_sh_r    <= '0;
      res_sum_r <= '0;
      res_gnt_r <= '0;
      res_vld_r <= 1'b0;
      sa_vld_r  <= 1'b0;
      sa_last_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r   <= ST_RUN;
            cnt_r     <= '0;
            a_sh_r    <= op_a_s;
            b_sh_r    <= op_b_s;
            res_gnt_r <= gnt_oh_s;
            sa_vld_r  <= 1'b1;
            sa_last_r <= (WIDTH == 1);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          res_sum_r[cnt_r] <= sa_sum;
          a_sh_r <= a_sh_r >> 1;
          b_sh_r <= b_sh_r >> 1;
          cnt_r  <= cnt_r + CW'(1);
          if (sa_last_r) begin
            state_r   <= ST_DONE;
            sa_vld_r  <= 1'b0;
            sa_last_r <= 1'b0;
            res_vld_r <= 1'b1;
          end else begin
            sa_last_r <= (int'(cnt_r) == WIDTH - 2);
          end
        end
        ST_DONE: begin
          if (res_rdy) begin
            state_r   <= ST_IDLE;
            res_vld_r <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          sa_vld_r  <= 1'b0;
          sa_last_r <= 1'b0;
          res_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign sa_rst  = sa_rst_sh_r[1];
  assign sa_vld  = sa_vld_r;
  assign sa_a    = a_sh_r[0];
  assign sa_b    = b_sh_r[0];
  assign sa_last = sa_last_r;
  assign res_vld = res_vld_r;
  assign res_sum = res_sum_r;
  assign res_gnt = res_gnt_r;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed testbench for serial_add_arbiter with a behavioural serial adder.
module tb_serial_add_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_vld;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_rdy;
  logic        res_vld;
  logic        res_rdy;
  logic [7:0]  res_sum;
  logic [3:0]  res_gnt;
  logic        sa_rst;
  logic        sa_vld;
  logic        sa_a;
  logic        sa_b;
  logic        sa_last;
  logic        sa_sum;
  logic        carry;

  int n_assert = 0;
  int n_fail   = 0;

  serial_add_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
    .req_rdy(req_rdy), .res_vld(res_vld), .res_rdy(res_rdy), .res_sum(res_sum),
    .res_gnt(res_gnt), .sa_rst(sa_rst), .sa_vld(sa_vld), .sa_a(sa_a),
    .sa_b(sa_b), .sa_last(sa_last), .sa_sum(sa_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural bit-serial adder: carry cleared by reset and after last bit.
  always @(posedge clk) begin
    if (sa_rst) carry <= 1'b0;
    else if (sa_vld) carry <= sa_last ? 1'b0 : ((sa_a & sa_b) | (sa_a & carry) | (sa_b & carry));
  end
  assign sa_sum = sa_a ^ sa_b ^ carry;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_rdy"}, 32'(req_rdy), 32'h0);
    chk({tag, "_res_vld"}, 32'(res_vld), 32'h0);
    chk({tag, "_sa_vld"},  32'(sa_vld),  32'h0);
    chk({tag, "_sa_rst"},  32'(sa_rst),  32'h1);
  endtask

  // One full operation from an idle, out-of-reset negedge.
  task automatic run_op(input logic [3:0] vld_pat, input int g, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_sum,
                        input bit keep, input int bp);
    logic [3:0] exp_oh;
    exp_oh = 4'b0001 << g;
    req_vld = vld_pat;
    req_a[g*8 +: 8] = a;
    req_b[g*8 +: 8] = b;
    res_rdy = (bp == 0);
    #1;
    chk("req_rdy_grant", 32'(req_rdy), 32'(exp_oh));
    @(negedge clk);
    if (!keep) req_vld = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      chk("sa_vld_run",  32'(sa_vld),  32'h1);
      chk("sa_a_bit",    32'(sa_a),    32'(a[k]));
      chk("sa_b_bit",    32'(sa_b),    32'(b[k]));
      chk("sa_last_bit", 32'(sa_last), 32'(k == 7));
      @(negedge clk);
    end
    for (int c = 0; c < bp; c++) begin
      chk("bp_res_vld", 32'(res_vld), 32'h1);
      chk("bp_res_sum", 32'(res_sum), 32'(exp_sum));
      chk("bp_req_rdy", 32'(req_rdy), 32'h0);
      @(negedge clk);
    end
    res_rdy = 1'b1;
    #1;
    chk("res_vld_done", 32'(res_vld), 32'h1);
    chk("res_sum",      32'(res_sum), 32'(exp_sum));
    chk("res_gnt",      32'(res_gnt), 32'(exp_oh));
    chk("sa_vld_done",  32'(sa_vld),  32'h0);
    chk("sa_a_done",    32'(sa_a),    32'h0);
    @(negedge clk);
    chk("res_vld_idle", 32'(res_vld), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g_rr [0:4];
`ifdef SERIAL_ADD_ARB_FIXED_PRIO_EN
    g_rr = '{0, 0, 0, 0, 0};
`else
    g_rr = '{0, 1, 2, 3, 0};
`endif
    // 1: reset held 3 clocks with requester 0 pending
    rst = 1'b0; res_rdy = 1'b1; req_vld = 4'b0001;
    req_a = 32'h0000_003C; req_b = 32'h0000_0005;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk_reset_outputs("rst_hold");
      chk("rst_res_sum", 32'(res_sum), 32'h0);
      chk("rst_res_gnt", 32'(res_gnt), 32'h0);
    end
    rst = 1'b1; #1;
    chk_reset_outputs("rel_0");
    @(negedge clk); #1;
    chk_reset_outputs("rel_1");
    @(negedge clk); #1;
    chk("sa_rst_low", 32'(sa_rst), 32'h0);

    // 2: single op on requester 0
    run_op(4'b0001, 0, 8'h3C, 8'h05, 8'h41, 1'b0, 0);

    // 3: wrap, then zero operands show the carry was cleared
    run_op(4'b0001, 0, 8'hFF, 8'h01, 8'h00, 1'b0, 0);
    run_op(4'b0001, 0, 8'h00, 8'h00, 8'h00, 1'b0, 0);

    // 5: back-pressure for 5 clocks, next grant one clock after release
    run_op(4'b0010, 1, 8'hA5, 8'h5A, 8'hFF, 1'b1, 5);
    run_op(4'b0010, 1, 8'h80, 8'h80, 8'h00, 1'b0, 0);

    // 6: reset asserted during bit 4 of an operation
    req_vld = 4'b0001; req_a[7:0] = 8'h77; req_b[7:0] = 8'h11; #1;
    chk("mid_req_rdy", 32'(req_rdy), 32'h1);
    @(negedge clk);
    req_vld = 4'b0000;
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("mid_sa_vld_pre", 32'(sa_vld), 32'h1);
    chk("mid_res_sum_pre", 32'(res_sum), 32'h08);
    rst = 1'b0; #1;
    chk_reset_outputs("mid_rst");
    chk("mid_res_sum", 32'(res_sum), 32'h0);
    chk("mid_res_gnt", 32'(res_gnt), 32'h0);
    chk("mid_sa_a",    32'(sa_a),    32'h0);
    chk("mid_sa_b",    32'(sa_b),    32'h0);
    chk("mid_sa_last", 32'(sa_last), 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_sa_rst_hold", 32'(sa_rst), 32'h1);
    @(negedge clk);

    // 4: round-robin with all requesters held; first op is the post-reset 0x12+0x34
    req_a = 32'h9_9F_0_01_12; req_b = 32'h9_90_F_02_34;
    req_a = {8'h99, 8'hF0, 8'h01, 8'h12};
    req_b = {8'h99, 8'h0F, 8'h02, 8'h34};
    run_op(4'b1111, g_rr[0], 8'h12, 8'h34, 8'h46, 1'b1, 0);
    run_op(4'b1111, g_rr[1], 8'h01, 8'h02, 8'h03, 1'b1, 0);
    run_op(4'b1111, g_rr[2], 8'hF0, 8'h0F, 8'hFF, 1'b1, 0);
    run_op(4'b1111, g_rr[3], 8'h99, 8'h99, 8'h32, 1'b1, 0);
    run_op(4'b1111, g_rr[4], 8'h3F, 8'h01, 8'h40, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
